// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads the synchronous instruction memory and buffers words for decode.
// Optional build macro INSTRUCTION_FETCH_HALT_ON_NOP_EN stops fetching after a 16'h0000 word is delivered.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int RESET_PC   = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] Mem_address,
  output logic                  Mem_wren,
  input  logic [DATA_WIDTH-1:0] Mem_q,
  input  logic                  Branch_taken,
  input  logic [ADDR_WIDTH-1:0] Branch_target,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [ADDR_WIDTH-1:0] Instr_pc,
  output logic                  Instr_valid,
  input  logic                  Instr_ready,
  output logic                  Halted
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [0:0]            state;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] fetch_pc_p1;
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] hold_instr;
  logic [ADDR_WIDTH-1:0] hold_pc;
  logic                  pop, push, issue, nop_hit;
  logic [CW:0]           occupancy;

  assign Mem_address = pc;
  assign Mem_wren    = 1'b0;
  assign Instr_valid = (count != '0);
  assign Instr       = Instr_valid ? data_mem[rd_ptr] : hold_instr;
  assign Instr_pc    = Instr_valid ? pc_mem[rd_ptr]   : hold_pc;

  // A redirect flushes everything, so neither the in-flight word nor a decode handshake counts.
  assign pop       = Instr_valid & Instr_ready & ~Branch_taken;
  assign push      = vld_p1 & ~Branch_taken;
  assign occupancy = {1'b0, count} + (CW+1)'(vld_p1) - (CW+1)'(pop);
  assign issue     = (state == RUN) & ~Branch_taken & (occupancy < DEPTH_C);

`ifdef INSTRUCTION_FETCH_HALT_ON_NOP_EN
  assign nop_hit = push & (Mem_q == '0);
  assign Halted  = (state == HALT);
`else
  assign nop_hit = 1'b0;
  assign Halted  = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc         <= ADDR_WIDTH'(RESET_PC);
      state      <= RUN;
      vld_p1     <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      hold_instr <= Instr;
      hold_pc    <= Instr_pc;
      if (Branch_taken) begin
        pc     <= Branch_target;
        state  <= RUN;
        vld_p1 <= 1'b0;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (issue) pc <= pc + 1'b1;
        // A fetch launched alongside the halting NOP is dropped on arrival.
        vld_p1 <= issue & ~nop_hit;
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
        if (nop_hit) state <= HALT;
      end
    end
  end

  // Stage p1: Q of the previous cycle's fetch lands in the buffer together with its address.
  always_ff @(posedge Clock) begin
    fetch_pc_p1 <= pc;
    if (push) begin
      data_mem[wr_ptr] <= Mem_q;
      pc_mem[wr_ptr]   <= fetch_pc_p1;
    end
  end

endmodule
